// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - UART transmitter serialising a multi-byte word, byte 0 first
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_BYTES    = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [8*MAX_BYTES-1:0]             in_data,
  input  logic [$clog2(MAX_BYTES+1)-1:0]     in_nbytes,
  output logic                               tx,
  output logic                               busy,
  output logic                               done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = $clog2(MAX_BYTES + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] NB_MAX    = NW'(MAX_BYTES);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [BW-1:0]          baud;
  logic [2:0]             bit_cnt;
  logic [NW-1:0]          byte_cnt;
  logic                   stop_cnt;
  logic [8*MAX_BYTES-1:0] word;
  logic [NW-1:0]          nbytes;

  logic [NW-1:0]          nb_clamped;
  logic [2:0]             bit_nxt;
  logic                   baud_end;
  logic                   par_bit;
  logic                   last_byte;

  // Byte-count clamp, next-bit index, end-of-bit strobe and parity of the current byte
  always_comb begin
    nb_clamped = (in_nbytes > NB_MAX) ? NB_MAX : in_nbytes;
    bit_nxt    = bit_cnt + 3'd1;
    baud_end   = (baud == BAUD_LAST);
    par_bit    = (^word[7:0]) ^ ODD;
    last_byte  = ((byte_cnt + NW'(1)) == nbytes);
  end

  // Framing FSM; the word register shifts right one byte per frame so byte 0 is always word[7:0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      stop_cnt <= 1'b0;
      word     <= '0;
      nbytes   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (nb_clamped == '0) begin
              done <= 1'b1;
            end else begin
              word     <= in_data;
              nbytes   <= nb_clamped;
              byte_cnt <= '0;
              baud     <= '0;
              tx       <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b0;
              state    <= START;
            end
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= word[0];
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
                state    <= STOP;
              end
            end else begin
              bit_cnt <= bit_nxt;
              tx      <= word[bit_nxt];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud     <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (stop_cnt == STOP_LAST) begin
              if (last_byte) begin
                tx       <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
                in_ready <= 1'b1;
                state    <= IDLE;
              end else begin
                byte_cnt <= byte_cnt + NW'(1);
                word     <= word >> 8;
                tx       <= 1'b0;
                state    <= START;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - self-checking bench for uart_word_tx over four framing configurations
module tb_uart_word_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [2:0]  in_nbytes = '0;
  logic        vld  [4];
  logic        rdy  [4];
  logic        txo  [4];
  logic        bsy  [4];
  logic        dn   [4];

  int checks = 0;
  int errors = 0;

  // instance configs: 0 plain, 1 even parity, 2 odd parity, 3 two stop bits
  int pen [4] = '{0, 1, 1, 0};
  int podd[4] = '{0, 0, 1, 0};
  int nstp[4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_word_tx #(
      .CLKS_PER_BIT(C),
      .MAX_BYTES   (4),
      .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (vld[g]),
      .in_ready (rdy[g]),
      .in_data  (in_data),
      .in_nbytes(in_nbytes),
      .tx       (txo[g]),
      .busy     (bsy[g]),
      .done     (dn[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge: offer the word for one edge
  task automatic launch(input int i, input logic [31:0] d, input logic [2:0] nb);
    in_data   = d;
    in_nbytes = nb;
    vld[i]    = 1'b1;
    check("in_ready_before_transfer", 32'(rdy[i]), 32'd1);
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
  endtask

  // reference line model: expected tx per cycle, then the done cycle; returns at the done-cycle negedge
  task automatic expect_word(input int i, input logic [31:0] d, input logic [2:0] nb);
    int   n;
    bit   q[$];
    logic [7:0] by;
    n = (nb > 3'd4) ? 4 : int'(nb);
    for (int b = 0; b < n; b++) begin
      by = d[8*b +: 8];
      q.push_back(1'b0);
      for (int k = 0; k < 8; k++) q.push_back(by[k]);
      if (pen[i] != 0) q.push_back((^by) ^ (podd[i] != 0));
      for (int s = 0; s < nstp[i]; s++) q.push_back(1'b1);
    end
    for (int j = 0; j < q.size(); j++) begin
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        check($sformatf("tx_inst%0d_bit%0d", i, j), 32'(txo[i]), 32'(q[j]));
        check("busy_during_word", 32'(bsy[i]), 32'd1);
        check("no_early_done", 32'(dn[i]), 32'd0);
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(dn[i]), 32'd1);
    check("idle_busy_at_done", 32'(bsy[i]), 32'd0);
    check("in_ready_at_done", 32'(rdy[i]), 32'd1);
    check("tx_high_at_done", 32'(txo[i]), 32'd1);
  endtask

  task automatic idle_after(input int i);
    @(negedge clk);
    check("done_single_cycle", 32'(dn[i]), 32'd0);
    check("idle_ready", 32'(rdy[i]), 32'd1);
    check("idle_tx", 32'(txo[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [2:0]  nb;
    int          i;
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("reset_tx", 32'(txo[k]), 32'd1);
      check("reset_busy", 32'(bsy[k]), 32'd0);
      check("reset_done", 32'(dn[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("ready_after_reset", 32'(rdy[k]), 32'd1);

    // single byte A5
    launch(0, 32'h0000_00A5, 3'd1);
    expect_word(0, 32'h0000_00A5, 3'd1);
    idle_after(0);

    // four bytes, then a word launched in the done cycle
    @(negedge clk);
    launch(0, 32'h4433_2211, 3'd4);
    expect_word(0, 32'h4433_2211, 3'd4);
    d = $urandom;
    launch(0, d, 3'd3);
    expect_word(0, d, 3'd3);
    idle_after(0);

    // parity even / odd on byte 07
    @(negedge clk);
    launch(1, 32'h0000_0007, 3'd1);
    expect_word(1, 32'h0000_0007, 3'd1);
    idle_after(1);
    @(negedge clk);
    launch(2, 32'h0000_0007, 3'd1);
    expect_word(2, 32'h0000_0007, 3'd1);
    idle_after(2);

    // two stop bits, two bytes
    @(negedge clk);
    d = $urandom;
    launch(3, d, 3'd2);
    expect_word(3, d, 3'd2);
    idle_after(3);

    // zero-byte word, then an over-length word
    @(negedge clk);
    launch(0, 32'hFFFF_FFFF, 3'd0);
    check("zero_tx_stays_high", 32'(txo[0]), 32'd1);
    expect_word(0, 32'hFFFF_FFFF, 3'd0);
    idle_after(0);
    d = $urandom;
    launch(0, d, 3'd7);
    expect_word(0, d, 3'd7);
    idle_after(0);

    // reset during byte 1 data bits
    @(negedge clk);
    launch(0, 32'hC3A5_5A3C, 3'd4);
    repeat (50) @(negedge clk);
    check("midword_busy", 32'(bsy[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(txo[0]), 32'd1);
    check("async_rst_busy", 32'(bsy[0]), 32'd0);
    check("async_rst_done", 32'(dn[0]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(dn[0]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("no_done_after_release", 32'(dn[0]), 32'd0);
    check("ready_after_abort", 32'(rdy[0]), 32'd1);
    d = $urandom;
    launch(0, d, 3'd2);
    expect_word(0, d, 3'd2);
    idle_after(0);

    // randomized words on random configurations
    for (int r = 0; r < 12; r++) begin
      i  = $urandom_range(0, 3);
      d  = $urandom;
      nb = 3'($urandom_range(0, 7));
      @(negedge clk);
      launch(i, d, nb);
      expect_word(i, d, nb);
      idle_after(i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal >= 2).
REQ-002 SHALL have parameter MAX_BYTES, default 4, bytes held per accepted word (legal 1..8).
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 inserts one parity bit after data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0; 0 even parity, 1 odd parity (ignored when PARITY_EN=0).
REQ-005 SHALL have parameter STOP_BITS, default 1, stop-bit count (legal 1 or 2).
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-007 SHALL have: rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have: in_valid  input  1  word offered.
REQ-009 SHALL have: in_ready  output  1  block can accept a word.
REQ-010 SHALL have: in_data  input  8*MAX_BYTES  word; byte k = in_data[8k+7:8k].
REQ-011 SHALL have: in_nbytes  input  $clog2(MAX_BYTES+1)  bytes of word to send.
REQ-012 SHALL have: tx  output  1  serial line, idle high.
REQ-013 SHALL have: busy  output  1  high while a word is being serialised.
REQ-014 SHALL have: done  output  1  single-cycle pulse at word completion.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a baud counter (0..CLKS_PER_BIT-1), bit counter (0..7), byte counter, and stop counter.
REQ-016 SHALL drive in_ready=1 only in IDLE; transfer occurs on a clk edge with in_valid && in_ready.
REQ-017 SHALL on transfer capture in_data and in_nbytes into internal registers, go to START; inputs ignored thereafter until IDLE.
REQ-018 SHALL clamp captured in_nbytes above MAX_BYTES to MAX_BYTES.
REQ-019 SHALL on transfer with in_nbytes=0 send nothing: stay in IDLE, tx stays 1, done pulses on the following cycle.
REQ-020 SHALL hold each line bit exactly CLKS_PER_BIT cycles; first start-bit cycle is the cycle after transfer.
REQ-021 SHALL frame each byte as: start (0), 8 data bits LSB first, parity (if PARITY_EN), STOP_BITS stop bits (1).
REQ-022 SHALL send byte 0 first, then byte 1, up to byte in_nbytes-1, back-to-back with no idle gap between frames.
REQ-023 SHALL compute parity as XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-024 SHALL after the last cycle of the final stop bit of the last byte return to IDLE, asserting done and in_ready in that same cycle.
REQ-025 SHALL allow a new transfer in the done cycle; its start bit then follows immediately (word-to-word gap 0).
REQ-026 SHALL drive busy=1 in every state other than IDLE, busy=0 in IDLE.
REQ-027 SHALL drive tx from a register (no combinational path from inputs to tx).
REQ-028 SHALL make one word of n bytes last exactly n*(9+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from first start-bit cycle to done.

Reset
REQ-029 SHALL on rst=1 immediately force state IDLE, tx=1, busy=0, done=0, in_ready=1 (after rst release), all counters and data registers 0.
REQ-030 SHALL on rst asserted mid-word abort the word with no done pulse; tx returns high asynchronously.

Verification (CLKS_PER_BIT=4, MAX_BYTES=4 unless stated)
REQ-031 SHALL cover: in_data=32'h0000_00A5, in_nbytes=1, no parity -> tx 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done at cycle 40.
REQ-032 SHALL cover: in_data=32'h4433_2211, in_nbytes=4 -> bytes 11,22,33,44 in order, no gaps, done after 160 cycles, busy high throughout.
REQ-033 SHALL cover: PARITY_EN=1, PARITY_ODD=0, byte 8'h07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 44 cycles.
REQ-034 SHALL cover: STOP_BITS=2, in_nbytes=2 -> each frame 11 bits (44 cycles), done at cycle 88.
REQ-035 SHALL cover: in_nbytes=0 -> tx stays 1, done pulses one cycle later; in_nbytes=7 -> sends 4 bytes.
REQ-036 SHALL cover: rst pulse during byte 1 data bits -> tx=1 and busy=0 same cycle, no done, next word transmits correctly.
